load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 58 +++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size codes
// and the default data-memory depth.
package lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 20;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE
  } lsu_state_e;

  // True when the size code is reserved or the byte offset breaks natural alignment.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load byte/half extraction with sign/zero
// extension, and store lane merge into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = mem_word;
    case (size)
      SIZE_BYTE: load_data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      SIZE_HALF: load_data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default:   load_data = mem_word;
    endcase
  end

  // Each lane decides independently whether the store owns it and which store byte feeds it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_src;

      always_comb begin
        lane_hit = 1'b0;
        lane_src = store_data[8*gi +: 8];
        case (size)
          SIZE_BYTE: begin
            lane_hit = (offset == LANE);
            lane_src = store_data[7:0];
          end
          SIZE_HALF: begin
            lane_hit = (offset[1] == LANE[1]);
            lane_src = store_data[8*(gi % 2) +: 8];
          end
          SIZE_WORD: lane_hit = 1'b1;
          default:   lane_hit = 1'b0;
        endcase
      end

      assign merged_word[8*gi +: 8] = lane_hit ? lane_src : mem_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a registered-read data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_reg;
  logic [1:0]  size_reg;
  logic [1:0]  offset_reg;
  logic        unsigned_reg;
  logic        we_reg;
  logic [31:0] wdata_reg;

  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        mem_we_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;

  logic [31:0] word_index;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign word_index = {2'b00, req_addr[31:2]};
  assign req_err    = bad_shape(req_size, req_addr[1:0]) || (word_index >= 32'(MEM_WORDS));
  assign req_ready  = (state_reg == ST_IDLE);

  lsu_align u_align (
    .mem_word    (mem_rdata),
    .offset      (offset_reg),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .store_data  (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      size_reg       <= SIZE_BYTE;
      offset_reg     <= 2'b00;
      unsigned_reg   <= 1'b0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_we_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            size_reg     <= req_size;
            offset_reg   <= req_addr[1:0];
            unsigned_reg <= req_unsigned;
            we_reg       <= req_we;
            wdata_reg    <= req_wdata;
            if (req_err) begin
              // Rejected requests answer immediately and never touch memory.
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
            end else begin
              mem_addr_reg <= word_index;
              if (req_we && req_size == SIZE_WORD) begin
                mem_we_reg    <= 1'b1;
                mem_wdata_reg <= req_wdata;
                state_reg     <= ST_WRITE;
              end else begin
                state_reg <= ST_READ;
              end
            end
          end
        end
        ST_READ: state_reg <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (we_reg) begin
            mem_we_reg    <= 1'b1;
            mem_wdata_reg <= merged_word;
            state_reg     <= ST_WRITE;
          end else begin
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= load_data;
            state_reg      <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= '0;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr   = mem_addr_reg;
  assign mem_we     = mem_we_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// word-array reference model with per-cycle response/write scheduling.
module tb_load_store_unit;

  localparam int NW = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Environment data memory with registered read.
  logic [31:0] env_mem [NW] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we && mem_addr < NW) env_mem[int'(mem_addr)] <= mem_wdata;
    mem_rdata <= (mem_addr < NW) ? env_mem[int'(mem_addr)] : 32'h0;
  end

  // Reference model state and expectation schedule.
  logic [31:0] ref_mem [NW] = '{default: 32'h0};
  typedef struct { int cyc; logic err; logic [31:0] rdata; } resp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int cyc = 0;
  int ready_cyc = 0;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int resp_cnt = 0;
  int last_resp_cyc = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_we_addr = 32'h0;
  logic [31:0] last_we_data = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, outputs must match the schedule exactly.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
    end else begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, (cyc >= ready_cyc)});
      if (mem_we) begin
        we_cnt++;
        last_we_addr = mem_addr;
        last_we_data = mem_wdata;
      end
      if (resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        last_err = resp_err;
        last_rdata = resp_rdata;
        $display("resp cyc=%0d err=%0b rdata=%08h", cyc, resp_err, resp_rdata);
      end
      if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
        chk("resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("resp_err", {31'b0, resp_err}, {31'b0, resp_q[0].err});
        chk("resp_rdata", resp_rdata, resp_q[0].rdata);
        void'(resp_q.pop_front());
      end else begin
        chk("resp_valid_idle", {31'b0, resp_valid}, 32'd0);
      end
      if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        chk("mem_we", {31'b0, mem_we}, 32'd1);
        chk("mem_addr", mem_addr, wr_q[0].addr);
        chk("mem_wdata", mem_wdata, wr_q[0].data);
        $display("write cyc=%0d addr=%0d data=%08h", cyc, mem_addr, mem_wdata);
        void'(wr_q.pop_front());
      end else begin
        chk("mem_we_idle", {31'b0, mem_we}, 32'd0);
      end
    end
  end

  // Issue one request; the model computes its result and timing at acceptance.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, output int n);
    int guard = 0;
    int nbytes;
    int idx;
    int sh;
    logic [31:0] mask;
    logic [31:0] v;
    logic bad;
    n = 0;
    while (!req_ready) begin
      // Noise while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_addr = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=busy required=ready");
        return;
      end
    end
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    n = cyc;
    req_valid = 1'b0;
    idx = int'(addr >> 2);
    sh = 8 * int'(addr[1:0]);
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= NW);
    nbytes = 1 << size;
    mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    if (bad) begin
      resp_q.push_back('{n, 1'b1, 32'h0});
      ready_cyc = n;
    end else if (!we) begin
      v = (ref_mem[idx] >> sh) & mask;
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
      resp_q.push_back('{n + 2, 1'b0, v});
      ready_cyc = n + 2;
    end else begin
      v = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[idx] = v;
      if (nbytes >= 4) begin
        wr_q.push_back('{n, 32'(idx), v});
        resp_q.push_back('{n + 1, 1'b0, 32'h0});
        ready_cyc = n + 1;
      end else begin
        wr_q.push_back('{n + 2, 32'(idx), v});
        resp_q.push_back('{n + 3, 1'b0, 32'h0});
        ready_cyc = n + 3;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while ((resp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && g < 60);
    if (g >= 60) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=pending required=drained");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    int r0;
    logic [31:0] saved;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Word store then word load at 0x08.
    w0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, n);
    wait_idle();
    chk("st_word_we_pulses", 32'(we_cnt - w0), 32'd1);
    chk("st_word_we_addr", last_we_addr, 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, n);
    wait_idle();
    chk("ld_word_rdata", last_rdata, 32'hDEADBEEF);
    chk("ld_word_err", {31'b0, last_err}, 32'd0);
    chk("ld_word_latency", 32'(last_resp_cyc - n), 32'd2);

    // Byte RMW and signed/unsigned byte loads.
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, n);
    do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AA, n);
    wait_idle();
    chk("st_byte_merge", last_we_data, 32'h1122AA44);
    do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, n);
    wait_idle();
    chk("ld_byte_signed", last_rdata, 32'hFFFFFFAA);
    do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, n);
    wait_idle();
    chk("ld_byte_unsigned", last_rdata, 32'h000000AA);

    // Halfword load and misaligned halfword store.
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h80011234, n);
    do_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, n);
    wait_idle();
    chk("ld_half_signed", last_rdata, 32'hFFFF8001);
    w0 = we_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h0B, 32'h5555, n);
    wait_idle();
    chk("st_half_misaligned_err", {31'b0, last_err}, 32'd1);
    chk("st_half_misaligned_no_we", 32'(we_cnt - w0), 32'd0);

    // Out-of-range index and reserved size.
    do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, n);
    wait_idle();
    chk("ld_range_err", {31'b0, last_err}, 32'd1);
    chk("ld_range_rdata", last_rdata, 32'd0);
    chk("ld_range_latency", 32'(last_resp_cyc - n), 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, n);
    wait_idle();
    chk("rsvd_size_err", {31'b0, last_err}, 32'd1);

    // Reset during CAPTURE of a byte store abandons it.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, n);
    wait_idle();
    saved = ref_mem[4];
    w0 = we_cnt;
    r0 = resp_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, n);
    @(negedge clk);
    #2;
    rst = 1'b1;
    resp_q.delete();
    wr_q.delete();
    ref_mem[4] = saved;
    ready_cyc = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_abort_no_we", 32'(we_cnt - w0), 32'd0);
    chk("rst_abort_no_resp", 32'(resp_cnt - r0), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, n);
    wait_idle();
    chk("rst_abort_word_kept", last_rdata, 32'hCAFEF00D);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a = {$urandom_range(0, 21), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, n);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
